// File: rtl/ppu_test_pattern_if.sv
// Pixel stream from the synthetic PPU source to the upscaler.
interface ppu_test_pattern_if;
  logic [23:0] rgb;
  logic [8:0]  px;
  logic [8:0]  py;
  logic        de;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    output rgb, px, py, de, frame_start, frame_count
  );

  modport slave (
    input rgb, px, py, de, frame_start, frame_count
  );
endinterface

// File: rtl/ppu_test_pattern.sv
// NES-timed test pattern source: walks the dot/line raster, builds one of four
// RGB patterns and presents each pixel a fixed LATENCY cycles later.
module ppu_test_pattern #(
  parameter logic [8:0]  SCREEN_WIDTH  = 9'd256,
  parameter logic [8:0]  SCREEN_HEIGHT = 9'd240,
  parameter logic [8:0]  FRAME_WIDTH   = 9'd341,
  parameter logic [8:0]  FRAME_HEIGHT  = 9'd262,
  parameter int unsigned LATENCY       = 3
) (
  input  logic                       clk_ppu,
  input  logic                       rst_ppu_n,
  input  logic [1:0]                 mode,
  input  logic                       freeze,
  input  logic                       odd_skip,
  ppu_test_pattern_if.master         pix
);

  localparam logic [8:0] X_LAST = FRAME_WIDTH - 9'd1;
  localparam logic [8:0] X_SKIP = FRAME_WIDTH - 9'd2;
  localparam logic [8:0] Y_LAST = FRAME_HEIGHT - 9'd1;

  typedef struct packed {
    logic [23:0] rgb;
    logic [8:0]  px;
    logic [8:0]  py;
    logic        de;
    logic        fs;
    logic [7:0]  fc;
  } pixel_t;

  logic [8:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [7:0] f_q, f_d;
  logic [1:0] mode_q, mode_d;

  logic       at_origin;
  logic       vis;
  logic       skip;
  logic       wrap;
  logic [1:0] mode_eff;
  logic [8:0] xs;
  logic [23:0] colour;
  pixel_t     stage0;
  pixel_t     pipe_q [LATENCY];

  assign at_origin = (x_q == 9'd0) && (y_q == 9'd0);
  assign vis       = (x_q < SCREEN_WIDTH) && (y_q < SCREEN_HEIGHT);
  // The origin pixel already uses the mode being latched this cycle.
  assign mode_eff  = at_origin ? mode : mode_q;
  assign xs        = 9'(x_q + {1'b0, f_q});

  // Raster advance, odd-frame dot skip, frame counter and mode latch.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    f_d    = f_q;
    mode_d = mode_q;
    skip   = odd_skip && f_q[0] && (x_q == X_SKIP) && (y_q == Y_LAST);
    wrap   = skip || ((x_q == X_LAST) && (y_q == Y_LAST));
    if (skip) begin
      x_d = 9'd0;
      y_d = 9'd0;
    end else if (x_q == X_LAST) begin
      x_d = 9'd0;
      y_d = (y_q == Y_LAST) ? 9'd0 : 9'(y_q + 9'd1);
    end else begin
      x_d = 9'(x_q + 9'd1);
    end
    if (wrap && !freeze) begin
      f_d = 8'(f_q + 8'd1);
    end
    if (at_origin) begin
      mode_d = mode;
    end
  end

  // Stage-0 colour for the current raster position.
  always_comb begin
    colour = 24'h000000;
    case (mode_eff)
      2'd0: colour = {f_q, ~f_q, 8'h80};
      2'd1: begin
        case (x_q[7:5])
          3'd0: colour = 24'hFFFFFF;
          3'd1: colour = 24'hFFFF00;
          3'd2: colour = 24'h00FFFF;
          3'd3: colour = 24'h00FF00;
          3'd4: colour = 24'hFF00FF;
          3'd5: colour = 24'hFF0000;
          3'd6: colour = 24'h0000FF;
          default: colour = 24'h000000;
        endcase
      end
      2'd2: colour = (xs[3] ^ y_q[3]) ? 24'hFFFFFF : 24'h000000;
      default: colour = {x_q[7:0], y_q[7:0], f_q};
    endcase
    if (!vis) begin
      colour = 24'h000000;
    end
  end

  // Bundle everything describing this pixel so it travels as one word.
  always_comb begin
    stage0.rgb = colour;
    stage0.px  = x_q;
    stage0.py  = y_q;
    stage0.de  = vis;
    stage0.fs  = at_origin;
    stage0.fc  = f_q;
  end

  // Raster state registers.
  always_ff @(posedge clk_ppu or negedge rst_ppu_n) begin
    if (!rst_ppu_n) begin
      x_q    <= 9'd0;
      y_q    <= 9'd0;
      f_q    <= 8'd0;
      mode_q <= 2'd0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      f_q    <= f_d;
      mode_q <= mode_d;
    end
  end

  // Fixed-length delay line; cleared on reset so no stale frame_start escapes.
  always_ff @(posedge clk_ppu or negedge rst_ppu_n) begin
    if (!rst_ppu_n) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign pix.rgb         = pipe_q[LATENCY-1].rgb;
  assign pix.px          = pipe_q[LATENCY-1].px;
  assign pix.py          = pipe_q[LATENCY-1].py;
  assign pix.de          = pipe_q[LATENCY-1].de;
  assign pix.frame_start = pipe_q[LATENCY-1].fs;
  assign pix.frame_count = pipe_q[LATENCY-1].fc;

endmodule

// File: tb/tb_ppu_test_pattern.sv
// Bench for ppu_test_pattern on a shrunken raster so full frames stay short.
`timescale 1ns/100ps
module tb_ppu_test_pattern;

  localparam int SW  = 36;
  localparam int SH  = 4;
  localparam int FW  = 40;
  localparam int FH  = 6;
  localparam int LAT = 3;
  localparam int FRAME_LEN = FW * FH;

  logic       clk_ppu = 1'b0;
  logic       rst_ppu_n = 1'b0;
  logic [1:0] mode = 2'd1;
  logic       freeze = 1'b0;
  logic       odd_skip = 1'b0;

  ppu_test_pattern_if pix_if ();

  ppu_test_pattern #(
    .SCREEN_WIDTH (9'(SW)),
    .SCREEN_HEIGHT(9'(SH)),
    .FRAME_WIDTH  (9'(FW)),
    .FRAME_HEIGHT (9'(FH)),
    .LATENCY      (LAT)
  ) dut (
    .clk_ppu  (clk_ppu),
    .rst_ppu_n(rst_ppu_n),
    .mode     (mode),
    .freeze   (freeze),
    .odd_skip (odd_skip),
    .pix      (pix_if.master)
  );

  always #5 clk_ppu = ~clk_ppu;

  int n_checks = 0;
  int n_fail   = 0;

  logic [51:0] exp_q [$];
  logic [51:0] cur_exp;
  int          m_k;
  logic [7:0]  m_f;
  logic [1:0]  m_mode;

  int          since_fs = -1;
  int          last_gap = 0;
  logic [7:0]  last_gap_fc = 8'd0;
  logic [7:0]  frame_fc = 8'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [51:0] dut_word();
    return {pix_if.rgb, pix_if.px, pix_if.py, pix_if.de, pix_if.frame_start, pix_if.frame_count};
  endfunction

  // Pattern rules written straight from the colour definitions.
  function automatic logic [23:0] ref_color(input int md, input int x, input int y, input int f);
    int bar;
    case (md)
      0: return {8'(f), 8'(255 - f), 8'h80};
      1: begin
        bar = (x / 32) % 8;
        case (bar)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2: return ((((x + f) % 512) / 8) % 2 != (y / 8) % 2) ? 24'hFFFFFF : 24'h000000;
      default: return {8'(x % 256), 8'(y % 256), 8'(f)};
    endcase
  endfunction

  // Frame modelled as a linear dot index; (x,y) derived by division.
  task automatic model_cycle();
    int x, y;
    logic vis;
    logic [23:0] c;
    x = m_k % FW;
    y = m_k / FW;
    if (m_k == 0) m_mode = mode;
    vis = (x < SW) && (y < SH);
    c = vis ? ref_color(int'(m_mode), x, y, int'(m_f)) : 24'h0;
    exp_q.push_back({c, 9'(x), 9'(y), vis, (m_k == 0), m_f});
    if (m_k == FRAME_LEN - 1 || (m_k == FRAME_LEN - 2 && odd_skip && m_f[0])) begin
      m_k = 0;
      if (!freeze) m_f = 8'(m_f + 8'd1);
    end else begin
      m_k++;
    end
  endtask

  task automatic model_reset();
    m_k = 0;
    m_f = 8'd0;
    m_mode = 2'd0;
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back(52'd0);
    since_fs = -1;
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk_ppu);
    #1;
    cur_exp = exp_q.pop_front();
    chk("pix", 64'(dut_word()), 64'(cur_exp));
    if (since_fs >= 0) since_fs++;
    if (pix_if.frame_start) begin
      if (since_fs > 0) begin
        last_gap = since_fs;
        last_gap_fc = frame_fc;
      end
      since_fs = 0;
      frame_fc = cur_exp[7:0];
    end
  endtask

  task automatic wait_pixel(input int x, input int y);
    int n;
    for (n = 0; n < 1000; n++) begin
      step();
      if (int'(pix_if.px) == x && int'(pix_if.py) == y) break;
    end
    if (n == 1000) chk("wait_pixel_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_fs();
    int n;
    for (n = 0; n < 1000; n++) begin
      step();
      if (pix_if.frame_start) break;
    end
    if (n == 1000) chk("wait_fs_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int sum;
    int wrapped;
    logic [7:0] frz_f;
    logic [7:0] pf;
    logic [23:0] cexp;

    // Reset and first-pixel latency.
    repeat (3) @(posedge clk_ppu);
    #1;
    chk("rst_out", 64'(dut_word()), 64'd0);
    rst_ppu_n = 1'b1;
    model_reset();
    chk("cyc0_zero", 64'(dut_word()), 64'd0);
    step();
    chk("cyc1_zero", 64'(dut_word()), 64'd0);
    step();
    chk("cyc2_zero", 64'(dut_word()), 64'd0);
    step();
    chk("lat_fs", 64'(pix_if.frame_start), 64'd1);
    chk("lat_pxpy", 64'({pix_if.px, pix_if.py}), 64'd0);
    chk("lat_rgb", 64'(pix_if.rgb), 64'hFFFFFF);
    chk("lat_de", 64'(pix_if.de), 64'd1);

    // Colour bars and blanking.
    wait_pixel(32, 0);
    chk("bar1_rgb", 64'(pix_if.rgb), 64'hFFFF00);
    wait_pixel(35, 2);
    chk("bar_edge_rgb", 64'(pix_if.rgb), 64'hFFFF00);
    chk("bar_edge_de", 64'(pix_if.de), 64'd1);
    wait_pixel(36, 2);
    chk("hblank_rgb", 64'(pix_if.rgb), 64'h0);
    chk("hblank_de", 64'(pix_if.de), 64'd0);
    wait_pixel(5, 4);
    chk("vblank_de", 64'(pix_if.de), 64'd0);

    // Mode change mid-frame only takes effect at the next frame.
    wait_pixel(10, 1);
    mode = 2'd3;
    wait_pixel(20, 3);
    chk("latch_hold_rgb", 64'(pix_if.rgb), 64'hFFFFFF);
    wait_pixel(5, 2);
    chk("latch_new_rgb", 64'(pix_if.rgb), 64'h050202);

    // Odd-frame dot skip.
    odd_skip = 1'b1;
    wait_fs();
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      wait_fs();
      chk("gap_skip", 64'(last_gap), 64'(FRAME_LEN - int'(last_gap_fc[0])));
      sum += last_gap;
    end
    chk("gap_skip_sum", 64'(sum), 64'(4 * FRAME_LEN - 2));
    odd_skip = 1'b0;
    wait_fs();
    for (int i = 0; i < 4; i++) begin
      wait_fs();
      chk("gap_noskip", 64'(last_gap), 64'(FRAME_LEN));
    end

    // Freeze holds the frame number and the checkerboard.
    mode = 2'd2;
    freeze = 1'b1;
    frz_f = frame_fc;
    for (int i = 0; i < 3; i++) begin
      wait_fs();
      chk("frz_fc", 64'(pix_if.frame_count), 64'(frz_f));
      wait_pixel(4, 1);
      cexp = (((4 + int'(frz_f)) / 8) % 2 != 0) ? 24'hFFFFFF : 24'h000000;
      chk("frz_chk_rgb", 64'(pix_if.rgb), 64'(cexp));
    end

    // Frame counter wraps 255 -> 0.
    freeze = 1'b0;
    wrapped = 0;
    for (int i = 0; i < 256; i++) begin
      pf = frame_fc;
      wait_fs();
      if (pf == 8'd255) begin
        chk("fc_wrap", 64'(pix_if.frame_count), 64'd0);
        wrapped++;
      end
    end
    chk("wrap_seen", 64'(wrapped), 64'd1);

    // Randomised control inputs, checked cycle by cycle against the model.
    for (int n = 0; n < 6 * FRAME_LEN; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        mode = 2'($urandom_range(0, 3));
        freeze = 1'($urandom_range(0, 1));
        odd_skip = 1'($urandom_range(0, 1));
      end
      step();
    end
    freeze = 1'b0;
    odd_skip = 1'b0;

    // Asynchronous reset pulse mid-frame.
    wait_pixel(20, 2);
    rst_ppu_n = 1'b0;
    #0.5;
    chk("midrst_low", 64'(dut_word()), 64'd0);
    #0.5;
    rst_ppu_n = 1'b1;
    chk("midrst_rel", 64'(dut_word()), 64'd0);
    model_reset();
    step();
    chk("midrst_c1_fs", 64'(pix_if.frame_start), 64'd0);
    step();
    chk("midrst_c2_fs", 64'(pix_if.frame_start), 64'd0);
    step();
    chk("midrst_fs", 64'(pix_if.frame_start), 64'd1);
    chk("midrst_pxpy", 64'({pix_if.px, pix_if.py}), 64'd0);
    chk("midrst_fc", 64'(pix_if.frame_count), 64'd0);
    wait_fs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
